vga_timing_gen: RTL
===================

# vga_timing_gen

Raster timing generator that produces the pixel coordinates consumed by `color_mapper` (`DrawX`, `DrawY`) plus the VGA sync and blanking strobes. It sits between the board clock and the display path. It advances a horizontal/vertical counter pair on a divided pixel tick. It delays `hs`/`vs`/`blank` by a programmable number of pixel ticks so they line up with RGB produced from synchronous-ROM lookups downstream.

## Interface
- `H_VISIBLE`, 640: visible pixels per line
- `H_FRONT`, 16 / `H_SYNC`, 96 / `H_BACK`, 48: horizontal porch/sync widths, in pixels
- `V_VISIBLE`, 480: visible lines per frame
- `V_FRONT`, 10 / `V_SYNC`, 2 / `V_BACK`, 33: vertical porch/sync widths, in lines
- `PIX_DIV`, 2: clocks per pixel tick (legal 1..8)
- `PIPE_LAT`, 1: pixel-tick delay applied to `hs`/`vs`/`blank` (legal 1..4)
- `Clk`  in  1: single clock for the whole block
- `Reset_n`  in  1: synchronous, active-low reset
- `pixel_en`  out  1: high for one `Clk` cycle per pixel tick
- `DrawX`  out  10: current horizontal count, 0..H_TOTAL-1
- `DrawY`  out  10: current vertical count, 0..V_TOTAL-1
- `hs`  out  1: horizontal sync, active-low, delayed by PIPE_LAT ticks
- `vs`  out  1: vertical sync, active-low, delayed by PIPE_LAT ticks
- `blank`  out  1: 1 = visible region and 0 = blanking (active-low blanking), delayed by PIPE_LAT ticks
- `frame_start`  out  1: one-cycle pulse when the counters wrap to (0,0)

## Operation
- Derived constants: H_TOTAL = sum of the H_* parameters (800 by default); V_TOTAL = sum of the V_* parameters (525 by default). Both must be ≤ 1024. An elaboration-time assertion fails otherwise.
- **Divider:** `div` counts 0..PIX_DIV-1 and wraps.
  - `pixel_en` = (`div` == PIX_DIV-1) && `Reset_n`.
  - For PIX_DIV=1, `pixel_en` is 1 every cycle outside reset.
- **Counters:** `hc`/`vc` update only on edges where `pixel_en` = 1.
  - `hc` wraps from H_TOTAL-1 to 0. `vc` increments on that wrap.
  - `vc` wraps from V_TOTAL-1 to 0 when `hc` also wraps.
  - `DrawX` = `hc` and `DrawY` = `vc`, driven directly from the registers.
- **Raw decode from (`hc`, `vc`):**
  - `hs_raw` = 0 iff H_VISIBLE+H_FRONT ≤ `hc` < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default).
  - `vs_raw` = 0 iff V_VISIBLE+V_FRONT ≤ `vc` < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default).
  - `blank_raw` = 1 iff `hc` < H_VISIBLE && `vc` < V_VISIBLE.
- **Delay line:** PIPE_LAT register stages for {`hs`, `vs`, `blank`}.
  - Every stage shifts only on `pixel_en`.
  - Stage 1 samples the raw decode of the pre-increment counter value.
  - So during the pixel period in which `DrawX` = k, `hs`/`blank` reflect the decode of pixel k-PIPE_LAT. This is computed modulo the frame and carries across line and frame boundaries.
- **frame_start:** registered; set to 1 for exactly one `Clk` on the edge where (`hc`, `vc`) transitions from (H_TOTAL-1, V_TOTAL-1) to (0,0). Otherwise 0.

## Timing
- **Reset values** (any edge with `Reset_n` = 0, including mid-frame, takes effect on that edge):
  - `div`=0, `hc`=`vc`=0, `DrawX`=`DrawY`=0
  - all delay stages = {`hs`=1, `vs`=1, `blank`=0}
  - `pixel_en`=0, `frame_start`=0
- **After reset release (first cycle with `Reset_n`=1 is cycle 0):**
  - First `pixel_en` occurs in cycle PIX_DIV-1.
  - `DrawX` becomes 1 on that edge.
  - Post-reset reset-valued stages flush after PIPE_LAT ticks. Until then the outputs show inactive values (`blank`=0 even though pixel 0 is visible).
- Each counter value is held for exactly PIX_DIV clocks.
- One frame = H_TOTAL·V_TOTAL·PIX_DIV clocks (840000 by default).
- Line wrap and frame wrap happen on the same `pixel_en` edge as the `hc` wrap. No extra cycle is inserted.
- `Reset_n` low coincident with `pixel_en`: reset wins; no counter advance.
- `frame_start` is not emitted for the reset-to-(0,0) transition, only for a natural wrap.

## Test plan
- **Reset then run, defaults:**
  - `pixel_en` pattern 0,1,0,1.
  - `DrawX` steps 0→1 at cycle 1; `DrawY`=0.
  - `blank`=0 for 1 tick, then 1.
- **Horizontal line, defaults:**
  - `hs`=0 while `DrawX` ∈ 657..752 (96 ticks, PIPE_LAT=1).
  - `blank` falls when `DrawX`=641 and rises again when `DrawX`=1 of the next line.
- **Vertical frame, defaults:**
  - `DrawY` wraps 524→0.
  - `vs` low for exactly 2·800 ticks.
  - `frame_start` pulses once every 840000 clocks, one cycle wide.
- **Parameter sweep, PIX_DIV=1 and PIPE_LAT=3:**
  - `pixel_en` constantly 1.
  - `hs` falls when `DrawX`=659.
  - Frame period 420000 clocks.
- **Mid-frame reset:**
  - Assert `Reset_n`=0 for 1 cycle at `DrawX`=700, `DrawY`=300.
  - Next cycle: all outputs at reset values.
  - Restart timing identical to the first scenario; no `frame_start` pulse.
- **Small custom timing, H=4/1/1/1, V=2/1/1/1:**
  - `DrawX` sequence 0..6 repeats.
  - `vs` low during line 3 (delayed 1 tick).
  - `frame_start` every 35·PIX_DIV clocks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: divided pixel tick, h/v counters, sync/blank decode and a
// tick-aligned delay line so the strobes match RGB coming out of ROM lookups.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int PIX_DIV   = 2,
   parameter int PIPE_LAT  = 1
) (
   input  logic       Clk,
   input  logic       Reset_n,
   output logic       pixel_en,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end
   if (PIX_DIV < 1 || PIX_DIV > 8) begin : g_bad_div
      $error("vga_timing_gen: PIX_DIV must be in 1..8");
   end
   if (PIPE_LAT < 1 || PIPE_LAT > 4) begin : g_bad_lat
      $error("vga_timing_gen: PIPE_LAT must be in 1..4");
   end

   localparam logic [2:0]  DIV_LAST = 3'(PIX_DIV - 1);
   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   // 11-bit bounds: a sync window may end exactly at 1024
   localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
   localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [2:0] div_reg;
   logic [9:0] hc_reg;
   logic [9:0] vc_reg;
   logic       frame_start_reg;
   logic       line_end;
   logic       frame_end;
   logic [10:0] hc_ext;
   logic [10:0] vc_ext;
   logic [2:0] raw_next;

   assign pixel_en  = (div_reg == DIV_LAST) && Reset_n;
   assign line_end  = (hc_reg == H_LAST);
   assign frame_end = line_end && (vc_reg == V_LAST);
   assign hc_ext    = {1'b0, hc_reg};
   assign vc_ext    = {1'b0, vc_reg};

   // {hs, vs, blank} decoded from the current (pre-increment) counters
   always_comb begin
      raw_next    = 3'b110;
      raw_next[2] = !((hc_ext >= HS_START) && (hc_ext < HS_END));
      raw_next[1] = !((vc_ext >= VS_START) && (vc_ext < VS_END));
      raw_next[0] = (hc_ext < H_VIS) && (vc_ext < V_VIS);
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         div_reg <= 3'd0;
      end else if (pixel_en) begin
         div_reg <= 3'd0;
      end else begin
         div_reg <= div_reg + 3'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         hc_reg          <= 10'd0;
         vc_reg          <= 10'd0;
         frame_start_reg <= 1'b0;
      end else begin
         frame_start_reg <= pixel_en && frame_end;
         if (pixel_en) begin
            if (line_end) begin
               hc_reg <= 10'd0;
               vc_reg <= (vc_reg == V_LAST) ? 10'd0 : vc_reg + 10'd1;
            end else begin
               hc_reg <= hc_reg + 10'd1;
            end
         end
      end
   end

   genvar gi;
   for (gi = 0; gi < PIPE_LAT; gi++) begin : g_stage
      logic [2:0] q_reg;
      logic [2:0] d_next;
      if (gi == 0) begin : g_src
         assign d_next = raw_next;
      end else begin : g_src
         assign d_next = g_stage[gi-1].q_reg;
      end
      always_ff @(posedge Clk) begin
         if (!Reset_n) begin
            q_reg <= 3'b110;
         end else if (pixel_en) begin
            q_reg <= d_next;
         end
      end
   end

   assign {hs, vs, blank} = g_stage[PIPE_LAT-1].q_reg;
   assign DrawX           = hc_reg;
   assign DrawY           = vc_reg;
   assign frame_start     = frame_start_reg;

endmodule
